// File: rtl/ysyx_040066_mem_responder.sv
// ysyx_040066_mem_responder: rd/wr bus memory endpoint, single beats and 8-beat line bursts.
// Optional YSYX_040066_MEM_RESP_STALL_EN inserts idle cycles after burst beats 1, 3 and 5.
module ysyx_040066_mem_responder #(
    parameter logic [63:0] MEM_BASE    = 64'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          RD_LAT      = 2,
    parameter int          WR_LAT      = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rd_req,
    input  logic         rd_burst,
    input  logic [2:0]   rd_len,
    input  logic [63:0]  rd_addr,
    output logic         rd_ready,
    output logic         rd_err,
    output logic         rd_last,
    output logic [63:0]  rd_data,
    input  logic         wr_req,
    input  logic         wr_burst,
    input  logic [2:0]   wr_len,
    input  logic [7:0]   wr_mask,
    input  logic [63:0]  wr_addr,
    input  logic [511:0] wr_data,
    output logic         wr_ready,
    output logic         wr_err
);
    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [63:0] SPAN = 64'(DEPTH_WORDS) * 64'd8;
`ifdef YSYX_040066_MEM_RESP_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BEAT, WR_WAIT, WR_DONE} state_t;

    logic [63:0]    mem [DEPTH_WORDS];
    state_t         state;
    logic [7:0]     cnt;
    logic [AW-1:0]  idx_q;
    logic           bst_q, err_q, gap;
    logic [2:0]     bidx;
    logic [7:0]     mask_q;
    logic [511:0]   data_q;
    logic [63:0]    a, off;
    logic           bst, err, do_wr;
    logic [2:0]     ln, nb;
    logic [AW-1:0]  idx;

    // Write wins arbitration, so the decode follows the write channel whenever it is requesting.
    always_comb begin
        a   = wr_req ? wr_addr : rd_addr;
        bst = wr_req ? wr_burst : rd_burst;
        ln  = wr_req ? wr_len : rd_len;
        off = a - MEM_BASE;
        idx = off[AW+2:3];
        err = (a < MEM_BASE) || (off >= SPAN) ||
              (!bst && ((ln > 3'd3) || ((a & ((64'd1 << ln) - 64'd1)) != 64'd0)));
        nb  = bidx + 3'd1;
    end

    assign do_wr = rst && state == WR_WAIT && cnt == 8'd0 && !err_q;

    always_ff @(posedge clk)
        if (do_wr)
            for (int k = 0; k < 8; k++)
                if (bst_q) mem[{idx_q[AW-1:3], 3'(k)}] <= data_q[64*k +: 64];
                else if (mask_q[k]) mem[idx_q][8*k +: 8] <= data_q[8*k +: 8];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            rd_ready <= 1'b0;
            rd_err   <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= 64'd0;
            wr_ready <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (wr_req) begin
                        state  <= WR_WAIT;
                        cnt    <= 8'(WR_LAT - 1);
                        idx_q  <= idx;
                        bst_q  <= wr_burst;
                        err_q  <= err;
                        mask_q <= wr_mask;
                        data_q <= wr_data;
                    end else if (rd_req) begin
                        state <= RD_WAIT;
                        cnt   <= 8'(RD_LAT - 1);
                        idx_q <= idx;
                        bst_q <= rd_burst;
                        err_q <= err;
                    end
                RD_WAIT:
                    if (cnt != 8'd0) cnt <= cnt - 8'd1;
                    else begin
                        state    <= RD_BEAT;
                        bidx     <= 3'd0;
                        gap      <= 1'b0;
                        rd_ready <= 1'b1;
                        rd_err   <= err_q;
                        rd_last  <= err_q || !bst_q;
                        rd_data  <= err_q ? 64'd0 : mem[bst_q ? {idx_q[AW-1:3], 3'd0} : idx_q];
                    end
                RD_BEAT:
                    if (rd_last) begin
                        state    <= IDLE;
                        rd_ready <= 1'b0;
                        rd_err   <= 1'b0;
                        rd_last  <= 1'b0;
                        rd_data  <= 64'd0;
                    end else if (STALL && !gap && bidx[0]) begin
                        rd_ready <= 1'b0;
                        gap      <= 1'b1;
                    end else begin
                        rd_ready <= 1'b1;
                        rd_data  <= mem[{idx_q[AW-1:3], nb}];
                        rd_last  <= nb == 3'd7;
                        bidx     <= nb;
                        gap      <= 1'b0;
                    end
                WR_WAIT:
                    if (cnt != 8'd0) cnt <= cnt - 8'd1;
                    else begin
                        state    <= WR_DONE;
                        wr_ready <= 1'b1;
                        wr_err   <= err_q;
                    end
                WR_DONE: begin
                    state    <= IDLE;
                    wr_ready <= 1'b0;
                    wr_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ysyx_040066_mem_responder.md
Name: ysyx_040066_mem_responder

Overview:
- Memory-side responder for the CPU's data/instruction bus; the other end of the rd_*/wr_* request channels that the core's caches and uncached path drive.
- Serves single-beat uncached accesses and 8-beat 64-byte cache-line bursts from an internal doubleword array.
- Used as the simulation/SoC memory endpoint; the instruction channel uses a second instance with wr_req tied low.

Parameters:
- MEM_BASE, 64'h8000_0000, byte address of the first array word
- DEPTH_WORDS, 4096, array depth in 64-bit words (power of two)
- RD_LAT, 2, cycles from read acceptance to the first rd_ready (≥1)
- WR_LAT, 2, cycles from write acceptance to wr_ready (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-low
- rd_req  in  1  read request; held until completion
- rd_burst  in  1  1 = 8-beat line read, 0 = single beat
- rd_len  in  3  access size log2 in bytes (0..3), single-beat only
- rd_addr  in  64  byte address
- rd_ready  out  1  beat valid
- rd_err  out  1  access error, qualified by rd_ready
- rd_last  out  1  final beat
- rd_data  out  64  beat data
- wr_req  in  1  write request; held until wr_ready
- wr_burst  in  1  1 = full-line write
- wr_len  in  3  size log2 in bytes, single-beat only
- wr_mask  in  8  byte enables, single-beat only
- wr_addr  in  64  byte address
- wr_data  in  512  line data; beat k = [64k+63:64k]; single-beat uses [63:0]
- wr_ready  out  1  write complete pulse
- wr_err  out  1  write error, qualified by wr_ready

Behaviour:
- Reset (rst=0 at a clk edge): FSM→IDLE; rd_ready, rd_err, rd_last, wr_ready, wr_err = 0; rd_data = 0. Array contents preserved. Reset mid-operation abandons the transfer with no further beats or partial write.
- FSM states: IDLE, RD_WAIT, RD_BEAT, WR_WAIT, WR_DONE.
- IDLE: wr_req has priority over rd_req when both are high, so a dirty eviction lands before its refill.
  - Accept samples addr/burst/len/mask/data into registers; the master must hold them stable, but the responder uses only the sampled copy.
  - Write accept → WR_WAIT; read accept → RD_WAIT; latency counter loaded.
- RD_WAIT: counts RD_LAT-1 cycles, then → RD_BEAT. The first rd_ready is asserted exactly RD_LAT cycles after the accept edge.
- RD_BEAT, burst: 8 consecutive rd_ready cycles. Beat k = word at (addr & ~63) + 8k, for k = 0..7. rd_last=1 on beat 7, then → IDLE.
- RD_BEAT, single: 1 cycle. rd_data = the aligned doubleword at addr & ~7, unshifted; rd_last=1. → IDLE.
- WR_WAIT: counts WR_LAT-1 cycles, then performs the write and → WR_DONE.
  - Burst: writes 8 words at line base.
  - Single: writes wr_data[63:0] bytes enabled by wr_mask at addr & ~7.
- WR_DONE: wr_ready=1 for exactly one cycle, so wr_ready is asserted WR_LAT cycles after accept. → IDLE. No new accept in the same cycle; the next accept is possible the following cycle.
- Error conditions (checked at accept):
  - address outside [MEM_BASE, MEM_BASE + DEPTH_WORDS*8);
  - single-beat with len > 3;
  - single-beat with addr not aligned to 1<<len.
- Error response:
  - Same timing as a normal access, but only one response cycle.
  - Reads: rd_ready=rd_err=rd_last=1 and rd_data=0, even for bursts.
  - Writes: wr_ready=wr_err=1 and the array is unmodified.
- Request dropped before completion: remaining beats are still emitted (no abort). The master must not reissue until completion.
- Word index = (addr - MEM_BASE)[log2(DEPTH_WORDS*8)-1:3]; no wrap-around, since out-of-range is an error.
- Outputs are registered; no combinational path from any input to any output.

Optional Feature:
- Macro: YSYX_040066_MEM_RESP_STALL_EN.
- Defined: in burst reads, one idle cycle (rd_ready=0) is inserted after beats 1, 3 and 5, so a burst spans 11 cycles from first to last beat. This stresses the cache refill counters.
- Undefined: beats are back-to-back, 8 cycles. Single beats and writes are unaffected either way.

Test Plan:
- Single write then read: wr addr 0x8000_0010, len 3, mask 0xFF, data 0x1122334455667788 → wr_ready 2 cycles after accept, err 0. Read of the same address → rd_ready+rd_last 2 cycles after accept, rd_data 0x1122334455667788.
- Masked write: mask 0x0F, data 0xAAAAAAAA_BBBBBBBB on the word above → readback 0x11223344_BBBBBBBB.
- Burst: line write at 0x8000_0040 with beat k = k+1; burst read at 0x8000_0058 → 8 consecutive beats with data 1..8, rd_last only on the 8th (11 cycles and bubbles if the stall macro is defined).
- Simultaneous rd_req (0x8000_0040) and wr_req (same line, beats 0xF0+k) → write completes first; the read then returns 0xF0..0xF7.
- Errors: read 0x7FFF_FFF8 → single rd_ready+rd_err+rd_last, data 0. Single write at 0x8000_0003 with len 1 → wr_err=1 and memory unchanged.
- Reset: rst=0 during burst beat 3 → next cycle all outputs 0, FSM IDLE. A subsequent read returns the pre-reset array contents.
